// File: rtl/cla_operand_sequencer.sv
// Operand source for the 2-bit CLA stage: switch passthrough or a 32-step a/b/ci walk (step/auto); 3-clk switch-to-output latency.
// No backpressure; optional CLA_SEQ_REVERSE_EN adds a synchronized dir input that makes each advance count down.
module cla_operand_sequencer #(
  parameter int DB_CYCLES = 500000,
  parameter int AUTO_DIV  = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic [1:0] mode,
  input  logic [1:0] sw_a,
  input  logic [1:0] sw_b,
  input  logic       sw_ci,
`ifdef CLA_SEQ_REVERSE_EN
  input  logic       dir,
`endif
  output logic [1:0] a,
  output logic [1:0] b,
  output logic       ci,
  output logic [4:0] idx,
  output logic       wrap
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PSW = $clog2(AUTO_DIV + 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_STEP   = 2'b01,
    ST_AUTO   = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  state_t           st, st_nxt;
  logic             btn_s1, btn_s2;
  logic [1:0]       mode_s1, mode_s2;
  logic [4:0]       sw_s1, sw_s2;
  logic             dir_s;
  logic [DBW-1:0]   db_cnt;
  logic             db_lvl, db_lvl_d;
  logic             step_pulse;
  logic [PSW-1:0]   psc;
  logic             psc_tc;
  logic             adv;
  logic [4:0]       idx_step;
  logic             wrap_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      mode_s1 <= 2'b00;
      mode_s2 <= 2'b00;
      sw_s1   <= 5'd0;
      sw_s2   <= 5'd0;
    end else begin
      btn_s1  <= btn_step;
      btn_s2  <= btn_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      sw_s1   <= {sw_a, sw_b, sw_ci};
      sw_s2   <= sw_s1;
    end
  end

`ifdef CLA_SEQ_REVERSE_EN
  logic dir_s1, dir_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      dir_s1 <= dir;
      dir_s2 <= dir_s1;
    end
  end
  assign dir_s = dir_s2;
`else
  assign dir_s = 1'b0;
`endif

  // Counter runs in every mode so a press that settles while in MANUAL is consumed there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      db_lvl_d <= 1'b0;
    end else begin
      db_lvl_d <= db_lvl;
      if (btn_s2 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_lvl <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign step_pulse = db_lvl & ~db_lvl_d;
  assign psc_tc     = (psc == PSW'(AUTO_DIV - 1));
  assign idx_step   = dir_s ? (idx - 5'd1) : (idx + 5'd1);
  assign wrap_hit   = dir_s ? (idx == 5'd0) : (idx == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_MANUAL;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = ST_MANUAL;
    adv    = 1'b0;
    case (mode_s2)
      2'b01:   st_nxt = ST_STEP;
      2'b10:   st_nxt = ST_AUTO;
      2'b11:   st_nxt = ST_HOLD;
      default: st_nxt = ST_MANUAL;
    endcase
    case (st)
      ST_STEP: adv = step_pulse;
      ST_AUTO: adv = psc_tc;
      default: adv = 1'b0;
    endcase
  end

  // Prescaler freezes outside AUTO and is cleared on entry, so the first advance is a full period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (st == ST_AUTO) begin
      psc <= psc_tc ? '0 : psc + PSW'(1);
    end else if (st_nxt == ST_AUTO) begin
      psc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= 2'd0;
      b    <= 2'd0;
      ci   <= 1'b0;
      idx  <= 5'd0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (st == ST_MANUAL) begin
        {a, b, ci} <= sw_s2;
        idx        <= sw_s2;
      end else begin
        a  <= idx[4:3];
        b  <= idx[2:1];
        ci <= idx[0];
        if (adv) begin
          idx  <= idx_step;
          wrap <= wrap_hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Cycle-level reference model feeds an expectation queue; a negedge monitor compares every DUT output cycle.
module tb_cla_operand_sequencer;

  localparam int DB  = 4;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] sw_a = 2'd0, sw_b = 2'd0;
  logic       sw_ci = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] a, b;
  logic       ci;
  logic [4:0] idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  cla_operand_sequencer #(.DB_CYCLES(DB), .AUTO_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .mode(mode),
    .sw_a(sw_a), .sw_b(sw_b), .sw_ci(sw_ci),
`ifdef CLA_SEQ_REVERSE_EN
    .dir(dir),
`endif
    .a(a), .b(b), .ci(ci), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [1:0] mode;
    logic [4:0] sw;
    logic       dir;
  } smp_t;

  logic [10:0] exp_q[$];
  smp_t        hist[$];
  int          lvl, run, rose, since, m_idx, ea, eb, eci, ewrap;

  task automatic model_reset();
    smp_t z;
    z = '{btn: 1'b0, mode: 2'b00, sw: 5'd0, dir: 1'b0};
    hist = {z, z, z};
    lvl = 0; run = 0; rose = 0; since = 0;
    m_idx = 0; ea = 0; eb = 0; eci = 0; ewrap = 0;
  endtask

  // Inputs reach the logic two edges late; the operating mode lags the pins by three edges.
  task automatic model_step();
    smp_t now, sy;
    int   st, pulse, adv, d, n;
    now   = '{btn: btn_step, mode: mode, sw: {sw_a, sw_b, sw_ci}, dir: dir};
    sy    = hist[1];
    st    = int'(hist[2].mode);
    pulse = rose;
    rose  = 0;
    if (int'(sy.btn) == lvl) run = 0;
    else if (run == DB - 1) begin
      lvl = int'(sy.btn); run = 0; rose = lvl;
    end else run++;
    adv = 0;
    if (st == 2) begin
      if (since == DIV - 1) begin adv = 1; since = 0; end
      else since++;
    end else since = 0;
    if (st == 1) adv = pulse;
    ewrap = 0;
    if (st == 0) begin
      ea = int'(sy.sw[4:3]); eb = int'(sy.sw[2:1]); eci = int'(sy.sw[0]);
      m_idx = int'(sy.sw);
    end else begin
      ea = m_idx / 8; eb = (m_idx / 2) % 4; eci = m_idx % 2;
      if (adv != 0) begin
        d = sy.dir ? -1 : 1;
        n = (m_idx + 32 + d) % 32;
        ewrap = (d == 1) ? int'(n == 0) : int'(n == 31);
        m_idx = n;
      end
    end
    hist.push_front(now);
    void'(hist.pop_back());
    exp_q.push_back({2'(ea), 2'(eb), 1'(eci), 5'(m_idx), 1'(ewrap)});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(11'd0);
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic [10:0] e, act;
    forever begin
      @(negedge clk);
      act = {a, b, ci, idx, wrap};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty @%0t actual=%h expected=none", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e)  begin
          errors++;
          $display("FAIL scoreboard @%0t actual a/b/ci/idx/wrap=%h expected=%h", $time, act, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_sw(input int v);
    sw_a  = 2'(v >> 3);
    sw_b  = 2'(v >> 1);
    sw_ci = 1'(v);
  endtask

  initial begin
    int w, found;
    rst_n = 1'b0; mode = 2'b10; btn_step = 1'b1;
    tick(5);
    chk("reset_idx", int'(idx), 0);
    chk("reset_abc", int'({a, b, ci}), 0);
    chk("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    tick(20);

    mode = 2'b00; set_sw(15);
    tick(6);
    chk("manual_idx", int'(idx), 15);
    chk("manual_abc", int'({a, b, ci}), 15);

    btn_step = 1'b0; tick(8);
    mode = 2'b01; tick(4);
    for (int i = 0; i < 10; i++) begin btn_step = ~btn_step; tick(2); end
    btn_step = 1'b1; tick(10);
    chk("bounce_idx", int'(idx), 16);
    chk("bounce_abc", int'({a, b, ci}), 16);
    btn_step = 1'b0; tick(10);
    btn_step = 1'b1; tick(10);
    chk("clean_press_idx", int'(idx), 17);
    btn_step = 1'b0;

    mode = 2'b00; set_sw(30); tick(6);
    chk("auto_start_idx", int'(idx), 30);
    mode = 2'b10;
    w = 0;
    for (int i = 0; i < 24; i++) begin tick(1); if (wrap) w++; end
    chk("auto_wrap_count", w, 1);
    chk("auto_wrap_idx", int'(idx), 0);

    mode = 2'b00; set_sw(4); tick(6);
    mode = 2'b10;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin tick(1); if (idx == 5'd5) found = 1; end
    chk("hold_reach5", found, 1);
    mode = 2'b11; tick(50);
    chk("hold_idx", int'(idx), 5);
    mode = 2'b10; tick(14);
    chk("resume_idx", int'(idx), 6);

    mode = 2'b00; set_sw(0); tick(6);
`ifdef CLA_SEQ_REVERSE_EN
    dir = 1'b1;
`endif
    mode = 2'b01; tick(5);
    btn_step = 1'b1; tick(10);
`ifdef CLA_SEQ_REVERSE_EN
    chk("reverse_idx", int'(idx), 31);
    chk("reverse_abc", int'({a, b, ci}), 31);
`else
    chk("forward_press_idx", int'(idx), 1);
`endif
    btn_step = 1'b0; tick(8);

    for (int seg = 0; seg < 200; seg++) begin
      int len;
      mode = 2'($urandom_range(0, 3));
      set_sw(int'($urandom_range(0, 31)));
`ifdef CLA_SEQ_REVERSE_EN
      dir = 1'($urandom_range(0, 1));
`endif
      len = int'($urandom_range(4, 60));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) btn_step = ~btn_step;
        tick(1);
      end
      if (seg == 100) begin
        rst_n = 1'b0; tick(3);
        rst_n = 1'b1;
      end
    end
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
